nco_modcnt: RTL and testbench

Parametrised successor to the fixed NCO-plus-mod-6 counter pair. A programmable divider produces a one-cycle tick every `num` clocks. A CNT_W-bit counter then advances on each tick, with runtime modulus, up/down direction, enable, synchronous load and a wrap (carry/borrow) pulse for cascading. Everything runs on the single system clock: no derived clock is produced, and downstream blocks consume `tick` and `carry` as clock enables.

---
 rtl/cnt_pkg.sv | 5 +
 rtl/nco_tick.sv | 31 +++
 rtl/nco_modcnt.sv | 69 ++++++
 tb/tb_nco_modcnt.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared width defaults for the NCO-driven modulo counter family.
package cnt_pkg;
  localparam int NCO_W_DEF = 32;
  localparam int CNT_W_DEF = 6;
endpackage

// File: rtl/nco_tick.sv
// Programmable divider: tick_i is high on the clock where the free-running
// count reaches num-1; num = 0 parks the count and suppresses ticks.
module nco_tick
  import cnt_pkg::*;
#(
  parameter int NCO_W = NCO_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCO_W-1:0] num,
  output logic             tick_i
);

  localparam logic [NCO_W-1:0] ONE = NCO_W'(1);

  logic [NCO_W-1:0] div_cnt;

  // >= rather than == so lowering num below the running count never overruns.
  assign tick_i = (num != '0) && (div_cnt >= (num - ONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if ((num == '0) || tick_i) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + ONE;
    end
  end

endmodule

// File: rtl/nco_modcnt.sv
// Up/down modulo counter advanced by a programmable divider tick, with
// synchronous load and a registered wrap pulse for cascading.
module nco_modcnt
  import cnt_pkg::*;
#(
  parameter int NCO_W = NCO_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCO_W-1:0] num,
  input  logic             en,
  input  logic             up_dn,
  input  logic [CNT_W-1:0] max_val,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] out,
  output logic             tick,
  output logic             carry
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic tick_i;

  nco_tick #(
    .NCO_W (NCO_W)
  ) u_nco_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .num    (num),
    .tick_i (tick_i)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out   <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else begin
      tick  <= tick_i;
      // NOTE: non-blocking default; a later branch in this block overrides it for this edge only.
      carry <= 1'b0;
      if (load) begin
        out <= (load_val > max_val) ? max_val : load_val;
      end else if (tick_i && en) begin
        if (up_dn) begin
          if (out >= max_val) begin
            out   <= '0;
            carry <= 1'b1;
          end else begin
            out <= out + ONE;
          end
        end else begin
          if (out == '0) begin
            out   <= max_val;
            carry <= 1'b1;
          end else if (out > max_val) begin
            // Modulus was lowered under us: clamp without signalling a wrap.
            out <= max_val;
          end else begin
            out <= out - ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nco_modcnt.sv
// Directed bench for nco_modcnt: a per-clock vector table plus hand-written
// sequences for divider phase, reset, num changes and enable gating.
module tb_nco_modcnt;
  localparam int NCO_W = 32;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCO_W-1:0] num;
  logic             en;
  logic             up_dn;
  logic [CNT_W-1:0] max_val;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] out;
  logic             tick;
  logic             carry;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [NCO_W-1:0] num;
    logic             en;
    logic             up_dn;
    logic [CNT_W-1:0] max_val;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] e_out;
    logic             e_tick;
    logic             e_carry;
  } vec_t;

  vec_t vecs[22];

  nco_modcnt #(
    .NCO_W (NCO_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .num      (num),
    .en       (en),
    .up_dn    (up_dn),
    .max_val  (max_val),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .tick     (tick),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int n, input bit e, input bit ud, input int mx,
                              input bit ld, input int lv, input int eo, input bit et,
                              input bit ec);
    vec_t v;
    v.num = NCO_W'(n);
    v.en = e;
    v.up_dn = ud;
    v.max_val = CNT_W'(mx);
    v.load = ld;
    v.load_val = CNT_W'(lv);
    v.e_out = CNT_W'(eo);
    v.e_tick = et;
    v.e_carry = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk3(input string name, input int eo, input bit et, input bit ec);
    check({name, ".out"}, 32'(out), 32'(eo));
    check({name, ".tick"}, 32'(tick), 32'(et));
    check({name, ".carry"}, 32'(carry), 32'(ec));
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp_out;
    bit et;

    rst_n = 1'b0; num = '0; en = 1'b0; up_dn = 1'b1;
    max_val = '0; load = 1'b0; load_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk3("reset", 0, 1'b0, 1'b0);

    // Basic up-count, num=4, max 5: updates on every 4th edge after release.
    rst_n = 1'b1; num = 4; en = 1'b1; up_dn = 1'b1; max_val = 5;
    for (int c = 1; c <= 24; c++) begin
      step();
      et = (c % 4 == 0);
      chk3($sformatf("up4[%0d]", c), (c / 4) % 6, et, et && ((c / 4) % 6 == 0));
    end

    // Table with num=1 (tick every clock): down wrap, enable, clip, max_val=0.
    vecs[0]  = mk(1, 1, 0, 9, 1, 0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) vecs[i] = mk(1, 1, 0, 9, 0, 0, (10 - i) % 10, 1, (i == 1));
    vecs[11] = mk(1, 1, 0, 9, 0, 0, 9, 1, 1);
    vecs[12] = mk(1, 0, 0, 9, 0, 0, 9, 1, 0);
    vecs[13] = mk(1, 1, 1, 9, 0, 0, 0, 1, 1);
    vecs[14] = mk(1, 1, 1, 9, 0, 0, 1, 1, 0);
    vecs[15] = mk(1, 1, 1, 9, 1, 12, 9, 1, 0);
    vecs[16] = mk(1, 1, 1, 0, 0, 0, 0, 1, 1);
    vecs[17] = mk(1, 1, 1, 0, 0, 0, 0, 1, 1);
    vecs[18] = mk(1, 1, 0, 0, 0, 0, 0, 1, 1);
    vecs[19] = mk(1, 1, 1, 5, 1, 7, 5, 1, 0);
    vecs[20] = mk(1, 1, 0, 2, 0, 0, 2, 1, 0);
    vecs[21] = mk(1, 1, 0, 2, 0, 0, 1, 1, 0);
    for (int i = 0; i < 22; i++) begin
      num = vecs[i].num; en = vecs[i].en; up_dn = vecs[i].up_dn;
      max_val = vecs[i].max_val; load = vecs[i].load; load_val = vecs[i].load_val;
      step();
      chk3($sformatf("vec[%0d]", i), int'(vecs[i].e_out), vecs[i].e_tick, vecs[i].e_carry);
    end

    // Mid-count reset, then load on a tick edge: clipped, no carry, phase kept.
    num = 4; en = 1'b1; up_dn = 1'b1; max_val = 9; load = 1'b0; load_val = 12;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk3("midreset", 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      load = (c == 8);
      step();
      et = (c % 4 == 0);
      if (c < 4) exp_out = 0;
      else if (c < 8) exp_out = 1;
      else if (c < 12) exp_out = 9;
      else exp_out = 0;
      chk3($sformatf("ldphase[%0d]", c), exp_out, et, (c == 12));
    end
    load = 1'b0;

    // num=0 halts the divider: nothing moves for 100 clocks.
    num = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      check($sformatf("halt.tick[%0d]", c), 32'(tick), 32'd0);
      check($sformatf("halt.out[%0d]", c), 32'(out), 32'd0);
    end

    // num 10 -> 3 with div_cnt at 7: immediate tick, then every 3 clocks.
    num = 10;
    for (int c = 1; c <= 7; c++) begin
      step();
      check($sformatf("n10.tick[%0d]", c), 32'(tick), 32'd0);
    end
    num = 3;
    exp_out = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      et = (c % 3 == 1);
      if (et) exp_out++;
      chk3($sformatf("n3[%0d]", c), exp_out, et, 1'b0);
    end

    // Disabled ticks still pulse tick but leave out alone.
    en = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      chk3($sformatf("dis[%0d]", c), 4, (c % 3 == 0), 1'b0);
    end

    // Lowered modulus while out is above it.
    num = 1; en = 1'b1; up_dn = 1'b1; max_val = 9; load = 1'b1; load_val = 4;
    step();
    chk3("lowmax.ld1", 4, 1'b1, 1'b0);
    load = 1'b0; max_val = 2;
    step();
    chk3("lowmax.up", 0, 1'b1, 1'b1);
    load = 1'b1; max_val = 9;
    step();
    chk3("lowmax.ld2", 4, 1'b1, 1'b0);
    load = 1'b0; max_val = 2; up_dn = 1'b0;
    step();
    chk3("lowmax.dn", 2, 1'b1, 1'b0);
    step();
    chk3("lowmax.dn2", 1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
